de2_115_onchip_mem_arbiter: RTL

//  Shares the single-port 32-bit on-chip RAM (1-cycle read latency, registered address) between two

---
 rtl/de2_115_onchip_mem_arbiter_if.sv | 25 ++
 rtl/de2_115_onchip_mem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/de2_115_onchip_mem_arbiter_if.sv
// One Avalon-MM master channel as seen by the on-chip RAM arbiter.
// The master drives the command; the arbiter answers with waitrequest and read data.
interface de2_115_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/de2_115_onchip_mem_arbiter.sv
// Round-robin arbiter sharing the single-port on-chip RAM between the Nios II data master (m0)
// and the Ethernet DMA (m1); zero-cycle grant, one access per cycle, bounded hold count.
module de2_115_onchip_mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  de2_115_onchip_mem_arbiter_if.slave m0,
  de2_115_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t              state, state_nxt;
  logic [3:0]          hold_cnt, hold_nxt;
  logic                last, last_nxt;
  logic                req0, req1, req_own, req_oth, own_sel;
  logic                gnt_vld, gnt_sel, gnt_en, rd_acc;
  logic [ADDR_W-1:0]   sel_addr, addr_hold;
  logic [DATA_W/8-1:0] sel_be, be_hold;
  logic [DATA_W-1:0]   sel_wdata, wdata_hold;
  logic                sel_read, sel_write;
  logic                rd_pend, rd_owner;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign own_sel = (state == OWN1);
  assign req_own = own_sel ? req1 : req0;
  assign req_oth = own_sel ? req0 : req1;

  // Stage p0: arbitration state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
    end
  end

  // Grant decision is made here too, since it shares every condition with the next state.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    gnt_vld   = 1'b0;
    gnt_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_vld   = 1'b1;
          gnt_sel   = (req0 & req1) ? ~last : req1;
          state_nxt = gnt_sel ? OWN1 : OWN0;
          hold_nxt  = 4'd1;
          last_nxt  = gnt_sel;
        end
      end
      OWN0, OWN1: begin
        if (req_own && (!req_oth || hold_cnt < HOLD_LIM)) begin
          gnt_vld  = 1'b1;
          gnt_sel  = own_sel;
          hold_nxt = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;
        end else if (req_oth) begin
          gnt_vld   = 1'b1;
          gnt_sel   = ~own_sel;
          state_nxt = own_sel ? OWN0 : OWN1;
          hold_nxt  = 4'd1;
          last_nxt  = ~own_sel;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_en    = gnt_vld & reset_n;
    sel_addr  = gnt_sel ? m1.address    : m0.address;
    sel_be    = gnt_sel ? m1.byteenable : m0.byteenable;
    sel_wdata = gnt_sel ? m1.writedata  : m0.writedata;
    sel_read  = gnt_sel ? m1.read       : m0.read;
    sel_write = gnt_sel ? m1.write      : m0.write;
    rd_acc    = gnt_en & sel_read & ~sel_write;

    m0.waitrequest = ~(gnt_en & ~gnt_sel);
    m1.waitrequest = ~(gnt_en & gnt_sel);

    mem_chipselect = gnt_en;
    mem_write      = gnt_en & sel_write;
    mem_address    = gnt_en ? sel_addr  : addr_hold;
    mem_byteenable = gnt_en ? sel_be    : be_hold;
    mem_writedata  = gnt_en ? sel_wdata : wdata_hold;
    mem_clken      = 1'b1;

    m0.readdata      = mem_readdata;
    m1.readdata      = mem_readdata;
    m0.readdatavalid = reset_n & rd_pend & ~rd_owner;
    m1.readdatavalid = reset_n & rd_pend & rd_owner;
  end

  // Stage p1: read-return tracking; a read in flight across reset is discarded
  always_ff @(posedge clk) begin
    if (!reset_n) rd_pend <= 1'b0;
    else          rd_pend <= rd_acc;
  end

  // Bus values of the last grant stay on the RAM pins while nobody is granted.
  always_ff @(posedge clk) begin
    rd_owner <= gnt_sel;
    if (gnt_en) begin
      addr_hold  <= sel_addr;
      be_hold    <= sel_be;
      wdata_hold <= sel_wdata;
    end
  end

endmodule
